// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue controller: operand fetch, ALU drive, write-back
//
// Accepts one decoded ALU instruction at a time, reads both operands from the
// general register file, drives the ALU for exactly one cycle, and writes the
// result back. It also holds the status flags and the HI/LO product registers.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   instr_*             instruction handshake and fields (op, rd, ra, rb)
//   rf_raddr_*/rf_rdata_*  register-file combinational read ports A/B
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   alu_a/alu_b/alu_op/alu_enable  ALU drive, valid for one cycle
//   alu_result/alu_overflow/alu_lt/alu_eq/alu_zero/alu_hi/alu_lo  ALU outputs
//   hi_q/lo_q           multiply HI/LO special registers
//   status_q            {eq, lt, v, z} from the last legal op
//   done/illegal        completion pulse; illegal marks an unsupported opcode
module alu_issue_ctrl #(
  parameter int RF_AW     = 2,
  parameter int MUL_WB_LO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [RF_AW-1:0] instr_rd,
  input  logic [RF_AW-1:0] instr_ra,
  input  logic [RF_AW-1:0] instr_rb,
  output logic [RF_AW-1:0] rf_raddr_a,
  output logic [RF_AW-1:0] rf_raddr_b,
  input  logic [7:0]       rf_rdata_a,
  input  logic [7:0]       rf_rdata_b,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [7:0]       rf_wdata,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_enable,
  input  logic [7:0]       alu_result,
  input  logic             alu_overflow,
  input  logic             alu_lt,
  input  logic             alu_eq,
  input  logic             alu_zero,
  input  logic [7:0]       alu_hi,
  input  logic [7:0]       alu_lo,
  output logic [7:0]       hi_q,
  output logic [7:0]       lo_q,
  output logic [3:0]       status_q,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1111;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [RF_AW-1:0] rd_q, ra_q, rb_q;
  logic [7:0]       opa_q, opb_q, res_q;
  logic [7:0]       hi_r, lo_r;
  logic [3:0]       status_r;
  logic             op_legal;

  always_comb begin
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b1100, 4'b1110, 4'b1111: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      status_r <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            op_q <= instr_op;
            rd_q <= instr_rd;
            ra_q <= instr_ra;
            rb_q <= instr_rb;
          end
        end
        S_READ: begin
          opa_q <= rf_rdata_a;
          opb_q <= rf_rdata_b;
        end
        S_EXEC: begin
          // Only legal ops reach EXEC, so illegal ops never disturb flags or HI/LO.
          res_q    <= alu_result;
          status_r <= {alu_eq, alu_lt, alu_overflow, alu_zero};
          if (op_q == OP_MUL) begin
            hi_r <= alu_hi;
            lo_r <= alu_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_raddr_a  = '0;
    rf_raddr_b  = '0;
    rf_we       = 1'b0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    alu_a       = '0;
    alu_b       = '0;
    alu_op      = '0;
    alu_enable  = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: begin
        rf_raddr_a = ra_q;
        rf_raddr_b = rb_q;
        state_d    = op_legal ? S_EXEC : S_WB;
      end
      S_EXEC: begin
        alu_enable = 1'b1;
        alu_op     = op_q;
        alu_a      = opa_q;
        alu_b      = opb_q;
        state_d    = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        illegal = !op_legal;
        if (op_legal) begin
          if (op_q == OP_MUL) begin
            rf_we    = (MUL_WB_LO != 0);
            rf_wdata = lo_r;
          end else if (op_q != OP_CMP) begin
            rf_we    = 1'b1;
            rf_wdata = res_q;
          end
        end
        if (rf_we) rf_waddr = rd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // While reset is held the controller presents an idle, quiet interface
    // regardless of which state it is being pulled out of.
    if (!rst) begin
      instr_ready = 1'b1;
      rf_raddr_a  = '0;
      rf_raddr_b  = '0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = '0;
      alu_enable  = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign hi_q     = rst ? hi_r : 8'h00;
  assign lo_q     = rst ? lo_r : 8'h00;
  assign status_q = rst ? status_r : 4'h0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl (MUL_WB_LO = 0 and 1)
module tb_alu_issue_ctrl;

  localparam int AW = 2;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       eq;
    logic       lt;
    logic       v;
    logic       z;
  } alu_t;

  typedef struct packed {
    logic [3:0]      op;
    logic            legal;
    logic [AW-1:0]   rd;
    logic [1:0][7:0] a;
    logic [1:0][7:0] b;
    logic [1:0]      we;
    logic [1:0][7:0] wdata;
    logic [1:0][7:0] hi;
    logic [1:0][7:0] lo;
    logic [1:0][3:0] st;
    int              t_acc;
    int              lat;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  logic          instr_valid;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_rd, instr_ra, instr_rb;
  logic          ld_en;
  logic [AW-1:0] ld_idx;
  logic [7:0]    ld_val;

  logic          instr_ready_w [2];
  logic [AW-1:0] rf_raddr_a_w  [2];
  logic [AW-1:0] rf_raddr_b_w  [2];
  logic [7:0]    rf_rdata_a_w  [2];
  logic [7:0]    rf_rdata_b_w  [2];
  logic          rf_we_w       [2];
  logic [AW-1:0] rf_waddr_w    [2];
  logic [7:0]    rf_wdata_w    [2];
  logic [7:0]    alu_a_w       [2];
  logic [7:0]    alu_b_w       [2];
  logic [3:0]    alu_op_w      [2];
  logic          alu_enable_w  [2];
  logic [7:0]    alu_result_w  [2];
  logic          alu_ovf_w     [2];
  logic          alu_lt_w      [2];
  logic          alu_eq_w      [2];
  logic          alu_zero_w    [2];
  logic [7:0]    alu_hi_w      [2];
  logic [7:0]    alu_lo_w      [2];
  logic [7:0]    hi_q_w        [2];
  logic [7:0]    lo_q_w        [2];
  logic [3:0]    status_q_w    [2];
  logic          done_w        [2];
  logic          illegal_w     [2];

  exp_t expq[$];

  logic [7:0] arch_rf [2][4];
  logic [7:0] m_hi [2];
  logic [7:0] m_lo [2];
  logic [3:0] m_st [2];

  logic       obs_we    [2];
  logic [7:0] obs_wdata [2];
  logic [1:0] obs_waddr [2];
  logic       obs_ill   [2];
  logic [7:0] obs_hi    [2];
  logic [7:0] obs_lo    [2];
  logic [3:0] obs_st    [2];
  int         obs_done_cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic alu_t alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    alu_t r;
    int sa, sb, t;
    logic [15:0] p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p = 16'(a) * 16'(b);
    r = '0;
    r.hi = p[15:8];
    r.lo = p[7:0];
    case (op)
      4'h0: begin t = sa + sb; r.res = a + b; r.v = (t > 127 || t < -128); end
      4'h1: begin t = sa - sb; r.res = a - b; r.v = (t > 127 || t < -128); end
      4'h2: r.res = p[7:0];
      4'h4: r.res = a << b[2:0];
      4'h5: r.res = a >> b[2:0];
      4'hC: r.res = a & b;
      4'hE, 4'hF: begin
        t = sa - sb;
        r.res = (sa < sb) ? 8'd1 : 8'd0;
        r.v = (t > 127 || t < -128);
      end
      default: r.res = 8'h00;
    endcase
    r.eq = (a == b);
    r.lt = (sa < sb);
    r.z  = (r.res == 8'h00);
    return r;
  endfunction

  function automatic bit op_is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'hC, 4'hE, 4'hF};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [7:0] mem [4];
    alu_t alu_s;

    always @(posedge clk) begin
      if (ld_en) mem[ld_idx] <= ld_val;
      else if (rf_we_w[g]) mem[rf_waddr_w[g]] <= rf_wdata_w[g];
    end

    assign rf_rdata_a_w[g] = mem[rf_raddr_a_w[g]];
    assign rf_rdata_b_w[g] = mem[rf_raddr_b_w[g]];

    always_comb alu_s = alu_fn(alu_op_w[g], alu_a_w[g], alu_b_w[g]);
    assign alu_result_w[g] = alu_s.res;
    assign alu_ovf_w[g]    = alu_s.v;
    assign alu_lt_w[g]     = alu_s.lt;
    assign alu_eq_w[g]     = alu_s.eq;
    assign alu_zero_w[g]   = alu_s.z;
    assign alu_hi_w[g]     = alu_s.hi;
    assign alu_lo_w[g]     = alu_s.lo;

    alu_issue_ctrl #(.RF_AW(AW), .MUL_WB_LO(g)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready_w[g]),
      .instr_op    (instr_op),
      .instr_rd    (instr_rd),
      .instr_ra    (instr_ra),
      .instr_rb    (instr_rb),
      .rf_raddr_a  (rf_raddr_a_w[g]),
      .rf_raddr_b  (rf_raddr_b_w[g]),
      .rf_rdata_a  (rf_rdata_a_w[g]),
      .rf_rdata_b  (rf_rdata_b_w[g]),
      .rf_we       (rf_we_w[g]),
      .rf_waddr    (rf_waddr_w[g]),
      .rf_wdata    (rf_wdata_w[g]),
      .alu_a       (alu_a_w[g]),
      .alu_b       (alu_b_w[g]),
      .alu_op      (alu_op_w[g]),
      .alu_enable  (alu_enable_w[g]),
      .alu_result  (alu_result_w[g]),
      .alu_overflow(alu_ovf_w[g]),
      .alu_lt      (alu_lt_w[g]),
      .alu_eq      (alu_eq_w[g]),
      .alu_zero    (alu_zero_w[g]),
      .alu_hi      (alu_hi_w[g]),
      .alu_lo      (alu_lo_w[g]),
      .hi_q        (hi_q_w[g]),
      .lo_q        (lo_q_w[g]),
      .status_q    (status_q_w[g]),
      .done        (done_w[g]),
      .illegal     (illegal_w[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: computes the architectural effect of an accepted
  // instruction and queues what the DUT must present when it completes.
  task automatic push_exp(input logic [3:0] op, input logic [AW-1:0] rd,
                          input logic [AW-1:0] ra, input logic [AW-1:0] rb, input int t);
    exp_t e;
    alu_t r;
    e = '0;
    e.op = op;
    e.rd = rd;
    e.legal = op_is_legal(op);
    e.t_acc = t;
    e.lat = e.legal ? 3 : 2;
    for (int g = 0; g < 2; g++) begin
      e.a[g] = arch_rf[g][ra];
      e.b[g] = arch_rf[g][rb];
      r = alu_fn(op, e.a[g], e.b[g]);
      if (e.legal) begin
        m_st[g] = {r.eq, r.lt, r.v, r.z};
        if (op == 4'h2) begin
          m_hi[g] = r.hi;
          m_lo[g] = r.lo;
          e.we[g] = (g == 1);
          e.wdata[g] = r.lo;
        end else if (op != 4'hF) begin
          e.we[g] = 1'b1;
          e.wdata[g] = r.res;
        end
      end
      e.hi[g] = m_hi[g];
      e.lo[g] = m_lo[g];
      e.st[g] = m_st[g];
      if (e.we[g]) arch_rf[g][rd] = e.wdata[g];
    end
    expq.push_back(e);
  endtask

  task automatic set_rf(input logic [AW-1:0] idx, input logic [7:0] val);
    ld_en = 1'b1;
    ld_idx = idx;
    ld_val = val;
    arch_rf[0][idx] = val;
    arch_rf[1][idx] = val;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] ra,
                       input logic [AW-1:0] rb, input bit hold, output int t);
    int n;
    n = 0;
    t = -1;
    instr_valid = 1'b1;
    instr_op = op;
    instr_rd = rd;
    instr_ra = ra;
    instr_rb = rb;
    while (t < 0) begin
      @(negedge clk);
      if (instr_ready_w[0] && rst) begin
        t = cyc;
        push_exp(op, rd, ra, rb, t);
      end else begin
        n++;
        if (n > 20) begin
          chk("accept_timeout", 32'd0, 32'd1);
          t = cyc;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (expq.size() > 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (n >= 30) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle protocol checks and completion scoreboard.
  initial begin : monitor
    exp_t e;
    bit   has;
    bit   exp_en, exp_done;
    forever begin
      @(negedge clk);
      if (!rst) begin
        expq.delete();
        for (int g = 0; g < 2; g++) begin
          chk("rst_ctl", {28'd0, rf_we_w[g], done_w[g], illegal_w[g], alu_enable_w[g]}, 32'd0);
          chk("rst_alu", {12'd0, alu_op_w[g], alu_a_w[g], alu_b_w[g]}, 32'd0);
          chk("rst_regs", {12'd0, hi_q_w[g], lo_q_w[g], status_q_w[g]}, 32'd0);
        end
      end else begin
        has = (expq.size() > 0);
        e = has ? expq[0] : '0;
        for (int g = 0; g < 2; g++) begin
          chk("instr_ready", 32'(instr_ready_w[g]), 32'(!(has && cyc > e.t_acc)));
          exp_en = has && e.legal && (cyc == e.t_acc + 2);
          chk("alu_enable", 32'(alu_enable_w[g]), 32'(exp_en));
          if (exp_en) begin
            chk("alu_op", 32'(alu_op_w[g]), 32'(e.op));
            chk("alu_a", 32'(alu_a_w[g]), 32'(e.a[g]));
            chk("alu_b", 32'(alu_b_w[g]), 32'(e.b[g]));
          end
          exp_done = has && (cyc == e.t_acc + e.lat);
          chk("done", 32'(done_w[g]), 32'(exp_done));
          if (exp_done) begin
            chk("illegal", 32'(illegal_w[g]), 32'(!e.legal));
            chk("rf_we", 32'(rf_we_w[g]), 32'(e.we[g]));
            if (e.we[g]) begin
              chk("rf_waddr", 32'(rf_waddr_w[g]), 32'(e.rd));
              chk("rf_wdata", 32'(rf_wdata_w[g]), 32'(e.wdata[g]));
            end
            chk("hi_q", 32'(hi_q_w[g]), 32'(e.hi[g]));
            chk("lo_q", 32'(lo_q_w[g]), 32'(e.lo[g]));
            chk("status_q", 32'(status_q_w[g]), 32'(e.st[g]));
            obs_we[g] = rf_we_w[g];
            obs_wdata[g] = rf_wdata_w[g];
            obs_waddr[g] = rf_waddr_w[g];
            obs_ill[g] = illegal_w[g];
            obs_hi[g] = hi_q_w[g];
            obs_lo[g] = lo_q_w[g];
            obs_st[g] = status_q_w[g];
            obs_done_cyc = cyc;
          end else begin
            chk("rf_we_idle", 32'(rf_we_w[g]), 32'd0);
            chk("illegal_idle", 32'(illegal_w[g]), 32'd0);
          end
        end
        if (has && cyc >= e.t_acc + e.lat) void'(expq.pop_front());
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int t, t2, prev_t, prev_lat;
    bit hold, prev_hold;
    logic [3:0] op;
    logic [7:0] saved_rf [2][4];
    rst = 1'b0;
    instr_valid = 1'b0;
    instr_op = '0;
    instr_rd = '0;
    instr_ra = '0;
    instr_rb = '0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_val = '0;
    for (int g = 0; g < 2; g++) begin
      m_hi[g] = '0;
      m_lo[g] = '0;
      m_st[g] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(instr_ready_w[0]), 32'd1);
    chk("reset_hilo", {16'd0, hi_q_w[0], lo_q_w[0]}, 32'd0);
    chk("reset_status", 32'(status_q_w[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_rf(AW'(i), 8'($urandom));

    // ADD 5+3 into r3
    set_rf(1, 8'd5);
    set_rf(2, 8'd3);
    issue(4'h0, 2'd3, 2'd1, 2'd2, 0, t);
    wait_idle();
    chk("add_we", 32'(obs_we[0]), 32'd1);
    chk("add_waddr", 32'(obs_waddr[0]), 32'd3);
    chk("add_wdata", 32'(obs_wdata[0]), 32'd8);
    chk("add_zv", 32'(obs_st[0][1:0]), 32'd0);
    chk("add_latency", 32'(obs_done_cyc - t), 32'd3);

    // SUB 7-7 into r0, then compare r1 with itself
    set_rf(1, 8'd7);
    set_rf(2, 8'd7);
    issue(4'h1, 2'd0, 2'd1, 2'd2, 0, t);
    wait_idle();
    chk("sub_wdata", 32'(obs_wdata[0]), 32'd0);
    chk("sub_z", 32'(obs_st[0][0]), 32'd1);
    issue(4'hF, 2'd2, 2'd1, 2'd1, 0, t);
    wait_idle();
    chk("cmp_we", 32'(obs_we[0]), 32'd0);
    chk("cmp_eq", 32'(obs_st[0][3]), 32'd1);

    // MUL 20*13 = 0x0104
    set_rf(1, 8'd20);
    set_rf(2, 8'd13);
    issue(4'h2, 2'd3, 2'd1, 2'd2, 0, t);
    wait_idle();
    chk("mul_hi", 32'(obs_hi[0]), 32'h01);
    chk("mul_lo", 32'(obs_lo[0]), 32'h04);
    chk("mul_we_lo0", 32'(obs_we[0]), 32'd0);
    chk("mul_we_lo1", 32'(obs_we[1]), 32'd1);
    chk("mul_wdata_lo1", 32'(obs_wdata[1]), 32'h04);
    chk("mul_latency", 32'(obs_done_cyc - t), 32'd3);

    // Signed compares
    set_rf(1, 8'hFD);
    set_rf(2, 8'd2);
    issue(4'hE, 2'd0, 2'd1, 2'd2, 0, t);
    wait_idle();
    chk("slt_wdata", 32'(obs_wdata[0]), 32'd1);
    chk("slt_lt", 32'(obs_st[0][2]), 32'd1);
    set_rf(1, 8'd127);
    set_rf(2, 8'h80);
    issue(4'hE, 2'd0, 2'd1, 2'd2, 0, t);
    wait_idle();
    chk("slt_ovf_lt", 32'(obs_st[0][2]), 32'd0);
    chk("slt_ovf_v", 32'(obs_st[0][1]), 32'd1);

    // Illegal opcode: status and HI/LO untouched, short latency
    issue(4'h3, 2'd1, 2'd1, 2'd2, 0, t);
    wait_idle();
    chk("ill_flag", 32'(obs_ill[0]), 32'd1);
    chk("ill_we", 32'(obs_we[0]), 32'd0);
    chk("ill_latency", 32'(obs_done_cyc - t), 32'd2);
    chk("ill_status", 32'(obs_st[0]), 32'b0011);
    chk("ill_hilo", {16'd0, obs_hi[0], obs_lo[0]}, 32'h0104);

    // Back-to-back with instr_valid held high
    issue(4'h3, 2'd0, 2'd0, 2'd0, 1, t);
    issue(4'h0, 2'd1, 2'd2, 2'd3, 1, t2);
    chk("b2b_after_illegal", 32'(t2 - t), 32'd3);
    issue(4'h5, 2'd2, 2'd1, 2'd0, 0, t);
    chk("b2b_after_legal", 32'(t - t2), 32'd4);
    wait_idle();

    // Randomized stream
    prev_hold = 0;
    prev_t = 0;
    prev_lat = 0;
    for (int i = 0; i < 150; i++) begin
      if (!prev_hold) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = 4'($urandom);
      hold = (i < 149) ? 1'($urandom) : 1'b0;
      issue(op, AW'($urandom), AW'($urandom), AW'($urandom), hold, t);
      if (prev_hold) chk("hold_spacing", 32'(t - prev_t), 32'(prev_lat + 1));
      prev_hold = hold;
      prev_t = t;
      prev_lat = op_is_legal(op) ? 3 : 2;
    end
    wait_idle();

    // Reset during EXEC drops the in-flight multiply
    set_rf(1, 8'd20);
    set_rf(2, 8'd13);
    issue(4'h2, 2'd0, 2'd1, 2'd2, 0, t);
    wait_idle();
    set_rf(1, 8'd9);
    set_rf(2, 8'd11);
    saved_rf = arch_rf;
    issue(4'h2, 2'd0, 2'd1, 2'd2, 0, t);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    arch_rf = saved_rf;
    for (int g = 0; g < 2; g++) begin
      m_hi[g] = '0;
      m_lo[g] = '0;
      m_st[g] = '0;
    end
    @(negedge clk);
    chk("post_rst_ready", 32'(instr_ready_w[1]), 32'd1);
    chk("post_rst_hilo", {16'd0, hi_q_w[1], lo_q_w[1]}, 32'd0);
    chk("post_rst_status", 32'(status_q_w[1]), 32'd0);
    @(posedge clk);
    #1;
    issue(4'h0, 2'd3, 2'd0, 2'd1, 0, t);
    wait_idle();
    chk("post_rst_rf_kept", 32'(obs_wdata[1]), 32'(saved_rf[1][0] + 8'd9));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
